// File: rtl/secure_key_fetch.sv
// Initiator-side controller for the secure key memory: issues single-cycle read/write
// strobes, captures a full slot on read-valid and streams it out MSW-first as OUT_W beats.
module secure_key_fetch #(
    parameter  int WIDTH   = 512,
    parameter  int LENGTH  = 6,
    parameter  int OUT_W   = 32,
    parameter  int TIMEOUT = 15,
    localparam int AW      = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AW-1:0]        req_addr,
    input  logic [WIDTH/2-1:0]   req_wdata,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [AW-1:0]        mem_addr,
    output logic [WIDTH/2-1:0]   mem_wrData,
    input  logic [WIDTH-1:0]     mem_rdData,
    input  logic                 mem_rdData_valid,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [OUT_W-1:0]     key_data,
    output logic                 key_last,
    output logic                 wr_done,
    output logic                 err
);

    localparam int BEATS = WIDTH / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t               r_state;
    logic                 r_req_ready;
    logic                 r_mem_rd_en;
    logic                 r_mem_wr_en;
    logic [AW-1:0]        r_mem_addr;
    logic [WIDTH/2-1:0]   r_mem_wrData;
    logic [WIDTH-1:0]     r_buf;
    logic [BW-1:0]        r_beat;
    logic [TW-1:0]        r_timer;
    logic                 r_key_valid;
    logic [OUT_W-1:0]     r_key_data;
    logic                 r_key_last;
    logic                 r_wr_done;
    logic                 r_err;

    logic                 w_addr_bad;
    logic                 w_reject;
    logic [WIDTH-1:0]     w_buf_shift;
    logic [BW-1:0]        w_beat_next;

    // Slot 0 holds the Chip ID and is read-only.
    assign w_addr_bad  = ({1'b0, req_addr} >= (AW+1)'(LENGTH));
    assign w_reject    = w_addr_bad || (req_write && (req_addr == '0));
    assign w_buf_shift = r_buf << OUT_W;
    assign w_beat_next = r_beat + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wrData <= '0;
            r_buf        <= '0;
            r_beat       <= '0;
            r_timer      <= '0;
            r_key_valid  <= 1'b0;
            r_key_data   <= '0;
            r_key_last   <= 1'b0;
            r_wr_done    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else if (req_write) begin
                            r_state      <= S_WRITE;
                            r_req_ready  <= 1'b0;
                            r_mem_wr_en  <= 1'b1;
                            r_mem_addr   <= req_addr;
                            r_mem_wrData <= req_wdata;
                        end else begin
                            r_state     <= S_READ;
                            r_req_ready <= 1'b0;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= req_addr;
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_wr_en <= 1'b0;
                    r_wr_done   <= 1'b1;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_READ: begin
                    r_mem_rd_en <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A valid on the last permitted cycle still wins over the timeout.
                    if (mem_rdData_valid) begin
                        r_buf       <= mem_rdData;
                        r_key_data  <= mem_rdData[WIDTH-1 -: OUT_W];
                        r_key_valid <= 1'b1;
                        r_key_last  <= (BEATS == 1);
                        r_beat      <= '0;
                        r_state     <= S_STREAM;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_err       <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (key_ready) begin
                        if (r_beat == BW'(BEATS - 1)) begin
                            r_buf       <= '0;
                            r_beat      <= '0;
                            r_key_valid <= 1'b0;
                            r_key_data  <= '0;
                            r_key_last  <= 1'b0;
                            r_req_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_buf      <= w_buf_shift;
                            r_key_data <= w_buf_shift[WIDTH-1 -: OUT_W];
                            r_beat     <= w_beat_next;
                            r_key_last <= (w_beat_next == BW'(BEATS - 1));
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_rd_en  = r_mem_rd_en;
    assign mem_wr_en  = r_mem_wr_en;
    assign mem_addr   = r_mem_addr;
    assign mem_wrData = r_mem_wrData;
    assign key_valid  = r_key_valid;
    assign key_data   = r_key_data;
    assign key_last   = r_key_last;
    assign wr_done    = r_wr_done;
    assign err        = r_err;

endmodule

// File: tb/tb_secure_key_fetch.sv
// Randomized bench for secure_key_fetch: behavioural key memory plus a slot-array
// reference model that predicts streamed beats, strobes and error pulses.
module tb_secure_key_fetch;

    localparam int WIDTH   = 512;
    localparam int LENGTH  = 6;
    localparam int OUT_W   = 32;
    localparam int TIMEOUT = 15;
    localparam int AW      = 3;
    localparam int BEATS   = WIDTH / OUT_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [AW-1:0]        req_addr;
    logic [WIDTH/2-1:0]   req_wdata;
    logic                 mem_rd_en;
    logic                 mem_wr_en;
    logic [AW-1:0]        mem_addr;
    logic [WIDTH/2-1:0]   mem_wrData;
    logic [WIDTH-1:0]     mem_rdData = '0;
    logic                 mem_rdData_valid = 1'b0;
    logic                 key_valid;
    logic                 key_ready;
    logic [OUT_W-1:0]     key_data;
    logic                 key_last;
    logic                 wr_done;
    logic                 err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    secure_key_fetch #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wrData(mem_wrData), .mem_rdData(mem_rdData),
        .mem_rdData_valid(mem_rdData_valid),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .key_last(key_last), .wr_done(wr_done), .err(err)
    );

    // Behavioural key memory: responds mem_lat cycles after the strobe cycle.
    logic [WIDTH-1:0] mem [0:7];
    logic             ld_en = 1'b0;
    logic [2:0]       ld_addr = '0;
    logic [WIDTH-1:0] ld_data = '0;
    int               mem_lat = 0;
    bit               mem_mute = 1'b0;
    bit               stale_valid = 1'b0;
    logic             pend = 1'b0;
    int               pend_cnt = 0;
    logic [2:0]       pend_addr = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (mem_wr_en) mem[mem_addr] <= {{(WIDTH/2){1'b0}}, mem_wrData};
        if (mem_rd_en && !mem_mute && mem_lat == 0) begin
            mem_rdData_valid <= 1'b1;
            mem_rdData       <= mem[mem_addr];
            pend             <= 1'b0;
        end else if (pend && pend_cnt == 0) begin
            mem_rdData_valid <= 1'b1;
            mem_rdData       <= mem[pend_addr];
            pend             <= 1'b0;
        end else begin
            mem_rdData_valid <= stale_valid;
            mem_rdData       <= {(WIDTH/32){$urandom()}};
            if (mem_rd_en && !mem_mute) begin
                pend      <= 1'b1;
                pend_cnt  <= mem_lat - 1;
                pend_addr <= mem_addr;
            end else if (pend) begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, hs_cnt = 0;
    always @(posedge clk) begin
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (key_valid && key_ready) hs_cnt <= hs_cnt + 1;
    end

    // Reference model: slot contents as the controller should see them.
    logic [WIDTH-1:0] ref_mem [0:7];

    function automatic logic [WIDTH-1:0] rand_wide();
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH/32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] exp_beat(input logic [WIDTH-1:0] s, input int i);
        logic [WIDTH-1:0] t;
        t = s >> (WIDTH - (i + 1) * OUT_W);
        return t[OUT_W-1:0];
    endfunction

    function automatic bit is_reject(input bit w, input int a);
        return (a >= LENGTH) || (w && a == 0);
    endfunction

    task automatic load_mem();
        for (int s = 0; s < 8; s++) begin
            ref_mem[s] = rand_wide();
            ld_en = 1'b1; ld_addr = 3'(s); ld_data = ref_mem[s];
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    // Drives one request from a negedge; returns at the negedge after the accept edge.
    task automatic issue(input bit w, input int a, input logic [WIDTH/2-1:0] d);
        int t = 0;
        while (req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_wait req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = w; req_addr = AW'(a); req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = $urandom(); req_addr = AW'($urandom()); req_wdata = '0;
    endtask

    // Called at the first cycle after a read accept.
    task automatic collect(input int slot, input int lat, input bit rand_ready,
                           input bit stale_in_stream, input int stop_at);
        logic [WIDTH-1:0] exp = ref_mem[slot];
        int cyc = 1, i = 0, rd0 = rd_cnt, hs0 = hs_cnt;
        bit first = 1'b0;
        vectors++;
        if (mem_rd_en !== 1'b1 || mem_addr !== AW'(slot) || mem_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_strobe rd_en=%b wr_en=%b addr=%0d required 1/0/%0d",
                     mem_rd_en, mem_wr_en, mem_addr, slot);
        end
        while (i < BEATS && cyc < 3 + lat + 200) begin
            if (stop_at >= 0 && i == stop_at) begin key_ready = 1'b0; break; end
            if (key_valid === 1'b1) begin
                if (!first) begin
                    first = 1'b1;
                    stale_valid = stale_in_stream;
                    vectors++;
                    if (cyc != 3 + lat) begin
                        miscompares++;
                        $display("FAIL read_latency got cycle %0d required %0d", cyc, 3 + lat);
                    end
                end
                vectors++;
                if (key_data !== exp_beat(exp, i) || key_last !== 1'(i == BEATS - 1)) begin
                    miscompares++;
                    $display("FAIL beat slot=%0d idx=%0d data=%h last=%b required %h/%b",
                             slot, i, key_data, key_last, exp_beat(exp, i), (i == BEATS - 1));
                end
                key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (key_ready) i++;
            end else begin
                vectors++;
                if (key_data !== '0 || key_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_key data=%h last=%b required 0/0", key_data, key_last);
                end
                key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        key_ready = 1'b0;
        stale_valid = 1'b0;
        if (stop_at >= 0) begin
            vectors++;
            if (i != stop_at || key_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stop_point beats=%0d valid=%b required %0d/1", i, key_valid, stop_at);
            end
            return;
        end
        vectors++;
        if (i != BEATS) begin
            miscompares++;
            $display("FAIL stream_timeout beats=%0d required %0d", i, BEATS);
        end
        vectors++;
        if (req_ready !== 1'b1 || key_valid !== 1'b0 || key_data !== '0) begin
            miscompares++;
            $display("FAIL stream_end req_ready=%b key_valid=%b key_data=%h required 1/0/0",
                     req_ready, key_valid, key_data);
        end
        @(negedge clk);
        vectors++;
        if (rd_cnt - rd0 != 1 || hs_cnt - hs0 != BEATS) begin
            miscompares++;
            $display("FAIL read_counts rd_pulses=%0d handshakes=%0d required 1/%0d",
                     rd_cnt - rd0, hs_cnt - hs0, BEATS);
        end
    endtask

    task automatic do_write(input int a, input logic [WIDTH/2-1:0] d);
        issue(1'b1, a, d);
        vectors++;
        if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== AW'(a) ||
            mem_wrData !== d || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_strobe wr_en=%b rd_en=%b addr=%0d data=%h ready=%b required 1/0/%0d/%h/0",
                     mem_wr_en, mem_rd_en, mem_addr, mem_wrData, req_ready, a, d);
        end
        @(negedge clk);
        vectors++;
        if (wr_done !== 1'b1 || req_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done done=%b ready=%b wr_en=%b required 1/1/0", wr_done, req_ready, mem_wr_en);
        end
        ref_mem[a] = {{(WIDTH/2){1'b0}}, d};
    endtask

    task automatic do_reject(input bit w, input int a);
        issue(w, a, '1);
        vectors++;
        if (err !== 1'b1 || req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reject w=%0d addr=%0d err=%b ready=%b rd=%b wr=%b required 1/1/0/0",
                     w, a, err, req_ready, mem_rd_en, mem_wr_en);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0 || wr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse err=%b wr_done=%b required 0/0", err, wr_done);
        end
    endtask

    task automatic do_read(input int a, input int lat, input bit rr, input bit stale);
        mem_lat = lat;
        issue(1'b0, a, '0);
        collect(a, lat, rr, stale, -1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 ||
                key_valid !== 1'b0 || key_data !== '0 || key_last !== 1'b0 ||
                wr_done !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state ready=%b rd=%b wr=%b kv=%b kd=%h kl=%b wd=%b err=%b required 1/0/0/0/0/0/0/0",
                         req_ready, mem_rd_en, mem_wr_en, key_valid, key_data, key_last, wr_done, err);
            end
        end
        rst_n = 1'b1;
        mem_lat = 0;
        @(negedge clk);
        req_valid = 1'b0;
        collect(2, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_read_latency();
        int lats[3] = '{1, 3, TIMEOUT - 1};
        foreach (lats[k]) do_read($urandom_range(1, LENGTH - 1), lats[k], 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_read(3, 0, 1'b1, 1'b1);
        do_read($urandom_range(0, LENGTH - 1), 2, 1'b1, 1'b1);
    endtask

    task automatic test_write_read();
        logic [63:0] pat = 64'h0123456789abcdef;
        do_write(1, {4{pat}});
        @(negedge clk);
        vectors++;
        if (wr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done_pulse wr_done=%b required 0", wr_done);
        end
        do_read(1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        int t = 0, err_cyc = -1;
        bit saw_kv = 1'b0;
        do_reject(1'b1, 0);
        do_reject(1'b0, 7);
        do_reject(1'b0, LENGTH);
        stale_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (key_valid !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stale_idle kv=%b err=%b ready=%b required 0/0/1", key_valid, err, req_ready);
            end
        end
        stale_valid = 1'b0;
        @(negedge clk);
        mem_mute = 1'b1;
        issue(1'b0, 4, '0);
        t = 1;
        while (t < TIMEOUT + 10) begin
            if (key_valid === 1'b1) saw_kv = 1'b1;
            if (err === 1'b1 && err_cyc < 0) begin
                err_cyc = t;
                vectors++;
                if (req_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL timeout_ready ready=%b required 1", req_ready);
                end
            end
            @(negedge clk);
            t++;
        end
        mem_mute = 1'b0;
        vectors++;
        if (err_cyc != TIMEOUT + 2 || saw_kv) begin
            miscompares++;
            $display("FAIL timeout err_cycle=%0d key_valid_seen=%0d required %0d/0", err_cyc, saw_kv, TIMEOUT + 2);
        end
    endtask

    task automatic test_back_to_back();
        int slots[4] = '{2, 3, 4, 5};
        foreach (slots[k]) do_write(slots[k], rand_wide()[WIDTH/2-1:0]);
        foreach (slots[k]) do_read(slots[k], 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int a = $urandom_range(0, 7);
            bit w = 1'($urandom_range(0, 1));
            if (is_reject(w, a)) do_reject(w, a);
            else if (w) do_write(a, rand_wide()[WIDTH/2-1:0]);
            else do_read(a, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        mem_lat = 0;
        issue(1'b0, 3, '0);
        collect(3, 0, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (key_valid !== 1'b0 || key_data !== '0 || key_last !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid kv=%b kd=%h kl=%b ready=%b required 0/0/0/1",
                     key_valid, key_data, key_last, req_ready);
        end
        rst_n = 1'b1;
        do_read(5, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; key_ready = 1'b0;
        @(negedge clk);
        load_mem();
        test_reset();
        test_read_latency();
        test_backpressure();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        vectors++;
        if (both_cnt != 0) begin
            miscompares++;
            $display("FAIL strobe_overlap cycles=%0d required 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
